// File: rtl/fifo_lane_packer_if.sv
// Show-ahead FIFO read port, flush request and packed-word output stream of fifo_lane_packer.
// master is the packer's view; slave is the FIFO/consumer side.
interface fifo_lane_packer_if #(
  parameter int Width = 8,
  parameter int Lanes = 4
);
  localparam int LanesOW = $clog2(Lanes + 1);

  logic                   fifo_empty_i;
  logic [Width-1:0]       fifo_data_i;
  logic                   fifo_read_o;
  logic                   flush_i;
  logic [Width*Lanes-1:0] word_o;
  logic                   valid_o;
  logic                   ready_i;
  logic                   last_o;
  logic [LanesOW-1:0]     lanes_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, flush_i, ready_i,
    output fifo_read_o, word_o, valid_o, last_o, lanes_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, flush_i, ready_i,
    input  fifo_read_o, word_o, valid_o, last_o, lanes_o
  );
endinterface

// File: rtl/fifo_lane_packer.sv
// Packs Lanes show-ahead FIFO elements into one wide word per valid/ready beat, with frame
// and flush boundaries emitted zero-padded; closing element popped at edge N is valid after N.
module fifo_lane_packer #(
  parameter int Width         = 8,
  parameter int Lanes         = 4,
  parameter int ElemsPerFrame = 10
) (
  input logic               clk_i,
  input logic               nrst_i,
  fifo_lane_packer_if.master bus
);
  localparam int LaneW   = $clog2(Lanes);
  localparam int FrameW  = (ElemsPerFrame > 1) ? $clog2(ElemsPerFrame) : 1;
  localparam int LanesOW = $clog2(Lanes + 1);
  localparam logic [LaneW-1:0]  LaneLast  = LaneW'(Lanes - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(ElemsPerFrame - 1);

  logic [LaneW-1:0]             lane_q, lane_d;
  logic [FrameW-1:0]            frame_q, frame_d;
  logic [Lanes-1:0][Width-1:0]  acc_q, acc_d;
  logic [Lanes-1:0][Width-1:0]  word_q, word_d;
  logic                         valid_q, valid_d;
  logic                         last_q, last_d;
  logic [LanesOW-1:0]           lanes_q, lanes_d;

  logic out_free, frame_end, closing, pop, flush_emit;

  // Only elements that would complete a word wait for the output register.
  always_comb begin
    out_free   = !valid_q || bus.ready_i;
    frame_end  = (frame_q == FrameLast);
    closing    = (lane_q == LaneLast) || frame_end || bus.flush_i;
    pop        = !bus.fifo_empty_i && (!closing || out_free);
    flush_emit = bus.flush_i && !pop && (lane_q != '0) && out_free;
  end

  always_comb begin
    lane_d  = lane_q;
    frame_d = frame_q;
    acc_d   = acc_q;
    word_d  = word_q;
    valid_d = valid_q && !bus.ready_i;
    last_d  = last_q;
    lanes_d = lanes_q;
    if (pop) begin
      acc_d[lane_q] = bus.fifo_data_i;
      if (closing) begin
        word_d  = acc_d;
        valid_d = 1'b1;
        last_d  = frame_end;
        lanes_d = LanesOW'(lane_q) + LanesOW'(1);
        acc_d   = '0;
        lane_d  = '0;
        frame_d = frame_end ? '0 : frame_q + FrameW'(1);
      end else begin
        lane_d  = lane_q + LaneW'(1);
        frame_d = frame_q + FrameW'(1);
      end
    end else if (flush_emit) begin
      // Partial word leaves mid-frame, so the frame count keeps running.
      word_d  = acc_q;
      valid_d = 1'b1;
      last_d  = 1'b0;
      lanes_d = LanesOW'(lane_q);
      acc_d   = '0;
      lane_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      lane_q  <= '0;
      frame_q <= '0;
      acc_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      lanes_q <= '0;
    end else begin
      lane_q  <= lane_d;
      frame_q <= frame_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      lanes_q <= lanes_d;
    end
  end

  assign bus.fifo_read_o = pop;
  assign bus.word_o      = word_q;
  assign bus.valid_o     = valid_q;
  assign bus.last_o      = last_q;
  assign bus.lanes_o     = lanes_q;
endmodule
